mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: COUNT_W, 16, width of WordCount and of the internal remaining-word counter.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 SrcAddr  input  32  byte address of first source word.
REQ-006 DstAddr  input  32  byte address of first destination word.
REQ-007 WordCount  input  COUNT_W  number of 32-bit words to copy.
REQ-008 Busy  output  1  high from the cycle after an accepted Start until Done.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 MemAddress  output  32  byte address to the memory responder.
REQ-011 MemWriteData  output  32  write data to the memory responder.
REQ-012 MemRead  output  1  read strobe.
REQ-013 MemWrite  output  1  write strobe.
REQ-014 MemReadData  input  32  combinational read data returned for the current MemAddress.

Function
REQ-015 FSM states: IDLE, READ, WRITE, DONE; encoding is taken from the shared package.
REQ-016 In IDLE with Start=1, the block SHALL latch SrcAddr and DstAddr with bits [1:0] cleared, latch WordCount, and go to READ, or to DONE if WordCount=0.
REQ-017 In READ: MemAddress=src pointer, MemRead=1, MemWrite=0; at the clock edge MemReadData is captured into the data register and the FSM moves to WRITE.
REQ-018 In WRITE: MemAddress=dst pointer, MemWriteData=data register, MemWrite=1, MemRead=0, for exactly one cycle.
REQ-019 At the WRITE exit edge: src and dst pointers +4 each, remaining count -1; next state is READ if remaining was >1, else DONE.
REQ-020 Throughput: exactly 2 cycles per word; latency from the Start edge to Done = 2*N+1 cycles for N>0, and 1 cycle for N=0.
REQ-021 DONE SHALL last one cycle with Done=1, Busy=0, then return to IDLE.
REQ-022 Busy=1 in READ and WRITE only.
REQ-023 Start outside IDLE is ignored, with no effect on the latched parameters.
REQ-024 Pointer increments wrap modulo 2^32 with no error indication.
REQ-025 Copy order is strictly ascending; an overlapping region with dst>src propagates the source data forward, and this is the defined behaviour.
REQ-026 MemRead and MemWrite SHALL never both be 1; both are 0 in IDLE and DONE.
REQ-027 All outputs decode from registered state only; there is no combinational path from inputs to outputs.
REQ-028 MemAddress=0 and MemWriteData=0 in IDLE and DONE.

Reset
REQ-029 Rst sampled high at an edge: state=IDLE, pointers, counter and data register = 0, on the same edge.
REQ-030 After that edge: Busy=0, Done=0, MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
REQ-031 Reset mid-copy aborts the copy with no Done pulse; words already written remain written.
REQ-032 Start asserted in the same cycle as Rst is ignored.

Structure
REQ-033 Package mem_copy_pkg holds the state enumeration and the constant WORD_BYTES=4.
REQ-034 Single module with no sub-modules; the memory responder is external.

Verification
REQ-035 Mem[0x100..0x10C]=11,22,33,44; Start with Src=0x100, Dst=0x200, N=4 -> Mem[0x200..0x20C]=11,22,33,44, Done 9 cycles after Start, exactly 4 MemWrite pulses.
REQ-036 N=0 -> Done on the next cycle, no MemRead/MemWrite pulses, Busy never high.
REQ-037 Src=0x103, Dst=0x201, N=1 -> read at 0x100, write at 0x200.
REQ-038 Src=0xFFFFFFFC, N=2 -> second read at 0x00000000.
REQ-039 Rst asserted during the 2nd WRITE of N=4 -> 1 word written, state IDLE, no Done pulse; 3rd and 4th destination words unchanged.
REQ-040 Start re-pulsed while Busy with different addresses -> original copy completes unchanged, and a subsequent Start in IDLE is accepted.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine.
//   state_e    : FSM state encoding (IDLE, READ, WRITE, DONE)
//   WORD_BYTES : byte stride between consecutive 32-bit words
package mem_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy engine: copies WordCount 32-bit words from SrcAddr to DstAddr,
// one read cycle and one write cycle per word, in ascending address order.
//
// Ports
//   Clk          in   clock, rising edge
//   Rst          in   synchronous active-high reset
//   Start        in   begin a copy (only honoured in IDLE)
//   SrcAddr      in   byte address of first source word (low 2 bits ignored)
//   DstAddr      in   byte address of first destination word (low 2 bits ignored)
//   WordCount    in   number of words to copy
//   Busy         out  copy in progress (READ/WRITE)
//   Done         out  one-cycle completion pulse
//   MemAddress   out  byte address to the memory responder
//   MemWriteData out  write data to the memory responder
//   MemRead      out  read strobe
//   MemWrite     out  write strobe
//   MemReadData  in   combinational read data for MemAddress
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for Start; all outputs 0
// ST_READ  | MemAddress = src pointer, capture MemReadData
// ST_WRITE | MemAddress = dst pointer, write captured word, advance
// ST_DONE  | one-cycle Done pulse, back to IDLE
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [31:0]        SrcAddr,
  input  logic [31:0]        DstAddr,
  input  logic [COUNT_W-1:0] WordCount,
  output logic               Busy,
  output logic               Done,
  output logic [31:0]        MemAddress,
  output logic [31:0]        MemWriteData,
  output logic               MemRead,
  output logic               MemWrite,
  input  logic [31:0]        MemReadData
);

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [31:0]        data_q, data_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               busy_q, done_q, rd_q, wr_q;
  logic [31:0]        addr_q, wdata_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          src_d   = {SrcAddr[31:2], 2'b00};
          dst_d   = {DstAddr[31:2], 2'b00};
          cnt_d   = WordCount;
          state_d = (WordCount == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        data_d  = MemReadData;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Pointers wrap naturally at 2^32.
        src_d   = src_q + 32'(WORD_BYTES);
        dst_d   = dst_q + 32'(WORD_BYTES);
        cnt_d   = cnt_q - COUNT_W'(1);
        state_d = (cnt_q > COUNT_W'(1)) ? ST_READ : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so that each output
  // reflects the state it is registered alongside, with no input-to-output
  // combinational path.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_READ) || (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      rd_q    <= (state_d == ST_READ);
      wr_q    <= (state_d == ST_WRITE);
      addr_q  <= (state_d == ST_READ)  ? src_d :
                 (state_d == ST_WRITE) ? dst_d : 32'd0;
      wdata_q <= (state_d == ST_WRITE) ? data_d : 32'd0;
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign MemRead      = rd_q;
  assign MemWrite     = wr_q;
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a per-cycle expected-output trace
// built from the copy rules, a reference memory image, and literal checks.
module tb_mem_copy_engine;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [31:0] SrcAddr;
  logic [31:0] DstAddr;
  logic [15:0] WordCount;
  logic        Busy;
  logic        Done;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  mem_copy_engine #(.COUNT_W(16)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Start        (Start),
    .SrcAddr      (SrcAddr),
    .DstAddr      (DstAddr),
    .WordCount    (WordCount),
    .Busy         (Busy),
    .Done         (Done),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nvec = 0;
  int nerr = 0;
  string cur_test = "reset";

  // Memory responder (1K words, indexed by address bits [11:2]).
  logic [31:0] dmem [0:1023];
  logic        mem_init;

  function automatic logic [31:0] init_val(int k);
    case (k)
      'h40: return 32'd11;
      'h41: return 32'd22;
      'h42: return 32'd33;
      'h43: return 32'd44;
      default: return 32'hA000_0000 | 32'(k);
    endcase
  endfunction

  assign MemReadData = dmem[MemAddress[11:2]];

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int k = 0; k < 1024; k++) dmem[k] <= init_val(k);
    end else if (MemWrite && !Rst) begin
      dmem[MemAddress[11:2]] <= MemWriteData;
    end
  end

  // Reference memory image updated by the model.
  logic [31:0] mmem [0:1023];

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic        wdchk;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(logic busy, logic done, logic rd, logic wr,
                              logic [31:0] addr, logic [31:0] wdata, logic wdchk);
    exp_t e;
    e.busy = busy; e.done = done; e.rd = rd; e.wr = wr;
    e.addr = addr; e.wdata = wdata; e.wdchk = wdchk;
    return e;
  endfunction

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, 32'd0, 32'd0, 1));
  endtask

  // Expected outputs for copy cycles 1..2N+1 after the Start edge: odd cycles
  // read word i, even cycles write it, final cycle is Done. A reset raised
  // during cycle rst_at leaves that cycle intact, suppresses its write, and
  // makes every later cycle idle.
  task automatic push_copy(logic [31:0] src, logic [31:0] dst, int n, int rst_at);
    logic [31:0] s, d, a, b, v;
    int i;
    s = src & ~32'd3;
    d = dst & ~32'd3;
    for (int c = 1; c <= 2*n + 1; c++) begin
      if (rst_at > 0 && c > rst_at) begin
        push_idle(1);
      end else if (c == 2*n + 1) begin
        exp_q.push_back(mk(0, 1, 0, 0, 32'd0, 32'd0, 1));
      end else if (c % 2 == 1) begin
        i = (c - 1) / 2;
        a = s + 32'(4 * i);
        exp_q.push_back(mk(1, 0, 1, 0, a, 32'd0, 0));
      end else begin
        i = c / 2 - 1;
        a = s + 32'(4 * i);
        b = d + 32'(4 * i);
        v = mmem[a[11:2]];
        exp_q.push_back(mk(1, 0, 0, 1, b, v, 1));
        if (!(rst_at > 0 && c == rst_at)) mmem[b[11:2]] = v;
      end
    end
  endtask

  // Per-cycle compare process.
  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nvec++;
      if (Busy !== e.busy || Done !== e.done || MemRead !== e.rd ||
          MemWrite !== e.wr || MemAddress !== e.addr ||
          (e.wdchk && MemWriteData !== e.wdata)) begin
        nerr++;
        $display("FAIL %s trace: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, expected busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h",
                 cur_test, Busy, Done, MemRead, MemWrite, MemAddress, MemWriteData,
                 e.busy, e.done, e.rd, e.wr, e.addr, e.wdata);
      end
    end
  end

  // Observation monitors.
  int cyc = 0;
  int start_cyc, done_cyc;
  int wr_pulses, rd_pulses, done_pulses, busy_seen;
  logic [31:0] rd_addrs[$];
  logic [31:0] wr_addrs[$];

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (MemWrite) begin wr_pulses++; wr_addrs.push_back(MemAddress); end
    if (MemRead)  begin rd_pulses++; rd_addrs.push_back(MemAddress); end
    if (Done)     begin done_pulses++; done_cyc = cyc; end
    if (Busy)     busy_seen++;
  end

  task automatic clear_obs(string name);
    cur_test = name;
    wr_pulses = 0; rd_pulses = 0; done_pulses = 0; busy_seen = 0;
    rd_addrs.delete(); wr_addrs.delete();
  endtask

  task automatic check32(string name, logic [31:0] got, logic [31:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
      @(negedge Clk); #1;
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s drain: got %0d pending cycles expected 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_copy(logic [31:0] src, logic [31:0] dst, int n, int rst_at,
                          int rp_at, logic [31:0] rp_src, logic [31:0] rp_dst, int rp_n);
    @(posedge Clk); #1;
    SrcAddr = src; DstAddr = dst; WordCount = 16'(n); Start = 1'b1;
    start_cyc = cyc;
    push_idle(1);
    push_copy(src, dst, n, rst_at);
    push_idle(1);
    for (int k = 1; k <= 2*n + 2; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      Rst   = 1'b0;
      if (k == rp_at) begin
        SrcAddr = rp_src; DstAddr = rp_dst; WordCount = 16'(rp_n); Start = 1'b1;
      end
      if (k == rst_at) Rst = 1'b1;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; WordCount = '0;
    mem_init = 1'b1;
    for (int k = 0; k < 1024; k++) mmem[k] = init_val(k);

    // Reset state.
    @(posedge Clk); #1;
    push_idle(3);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0; mem_init = 1'b0;
    drain();

    // Four-word copy.
    clear_obs("copy4");
    run_copy(32'h100, 32'h200, 4, 0, 0, 0, 0, 0);
    check32("copy4 dst0", dmem['h80], 32'd11);
    check32("copy4 dst1", dmem['h81], 32'd22);
    check32("copy4 dst2", dmem['h82], 32'd33);
    check32("copy4 dst3", dmem['h83], 32'd44);
    check32("copy4 writes", 32'(wr_pulses), 32'd4);
    check32("copy4 latency", 32'(done_cyc - start_cyc), 32'd9);

    // Zero-length copy.
    clear_obs("zero");
    run_copy(32'h100, 32'h2F0, 0, 0, 0, 0, 0, 0);
    check32("zero latency", 32'(done_cyc - start_cyc), 32'd1);
    check32("zero reads", 32'(rd_pulses), 32'd0);
    check32("zero writes", 32'(wr_pulses), 32'd0);
    check32("zero busy", 32'(busy_seen), 32'd0);

    // Unaligned addresses are truncated to word boundaries.
    clear_obs("unaligned");
    run_copy(32'h103, 32'h201, 1, 0, 0, 0, 0, 0);
    check32("unaligned rd addr", (rd_addrs.size() > 0) ? rd_addrs[0] : 32'hFFFF_FFFF, 32'h100);
    check32("unaligned wr addr", (wr_addrs.size() > 0) ? wr_addrs[0] : 32'hFFFF_FFFF, 32'h200);

    // Source pointer wrap.
    clear_obs("wrap");
    run_copy(32'hFFFF_FFFC, 32'h240, 2, 0, 0, 0, 0, 0);
    check32("wrap 2nd rd addr", (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hFFFF_FFFF, 32'h0);
    check32("wrap dst1", dmem['h91], 32'hA000_0000);

    // Reset during the second write.
    clear_obs("reset_mid");
    run_copy(32'h100, 32'h300, 4, 4, 0, 0, 0, 0);
    check32("reset_mid dst0", dmem['hC0], 32'd11);
    check32("reset_mid dst1", dmem['hC1], 32'hA000_00C1);
    check32("reset_mid dst2", dmem['hC2], 32'hA000_00C2);
    check32("reset_mid dst3", dmem['hC3], 32'hA000_00C3);
    check32("reset_mid done", 32'(done_pulses), 32'd0);

    // Start re-pulsed while busy is ignored.
    clear_obs("repulse");
    run_copy(32'h100, 32'h280, 3, 0, 2, 32'h0, 32'h380, 1);
    check32("repulse dst0", dmem['hA0], 32'd11);
    check32("repulse dst1", dmem['hA1], 32'd22);
    check32("repulse dst2", dmem['hA2], 32'd33);
    check32("repulse other dst", dmem['hE0], 32'hA000_00E0);
    check32("repulse done", 32'(done_pulses), 32'd1);
    clear_obs("after_repulse");
    run_copy(32'h108, 32'h2C0, 1, 0, 0, 0, 0, 0);
    check32("after_repulse dst", dmem['hB0], 32'd33);

    // Start in the same cycle as reset.
    clear_obs("start_rst");
    @(posedge Clk); #1;
    Rst = 1'b1; Start = 1'b1; SrcAddr = 32'h100; DstAddr = 32'h3C0; WordCount = 16'd2;
    push_idle(4);
    @(posedge Clk); #1;
    Rst = 1'b0; Start = 1'b0;
    drain();
    check32("start_rst busy", 32'(busy_seen), 32'd0);

    // Overlapping forward copy propagates the first word.
    clear_obs("overlap");
    run_copy(32'h100, 32'h104, 3, 0, 0, 0, 0, 0);
    check32("overlap dst0", dmem['h41], 32'd11);
    check32("overlap dst1", dmem['h42], 32'd11);
    check32("overlap dst2", dmem['h43], 32'd11);

    // Whole memory image against the model.
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 1024; k++) if (dmem[k] !== mmem[k]) bad++;
      check32("memory image diffs", 32'(bad), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
